// File: rtl/key_port_pkg.sv
// key_port shared definitions: register map, idle level, count limit.
// Imported by the key debouncer and the key_port top.
package key_port_pkg;

    localparam logic [1:0] KP_STATE   = 2'd0;
    localparam logic [1:0] KP_PRESS   = 2'd1;
    localparam logic [1:0] KP_RELEASE = 2'd2;
    localparam logic [1:0] KP_PCOUNT  = 2'd3;

    localparam logic       KP_KEY_IDLE   = 1'b1;
    localparam logic [7:0] KP_PCOUNT_MAX = 8'd255;

    function automatic logic [7:0] kp_sat_add(
        input logic [7:0] a,
        input logic [7:0] b
    );
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[8] ? KP_PCOUNT_MAX : s[7:0];
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One key: 2-flop synchroniser, debounce counter and stable level.
// rise/fall strobe in the same cycle st is updated.
module key_debounce
    import key_port_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic st,
    output logic rise,
    output logic fall
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic          key_s;
    logic          accept;

    assign key_s  = ~sync[1];
    assign accept = (key_s != st) && (cnt == CNT_MAX);
    assign rise   = accept & key_s;
    assign fall   = accept & ~key_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= {2{KP_KEY_IDLE}};
            st   <= 1'b0;
            cnt  <= '0;
        end else begin
            sync <= {sync[0], key};
            if (key_s == st) begin
                cnt <= '0;
            end else if (accept) begin
                st  <= key_s;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/key_port.sv
// Memory-mapped key input port: sticky press/release flags,
// saturating press counter and a combinational read mux.
module key_port
    import key_port_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int NKEYS           = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [NKEYS-1:0] KEY,
    input  logic [1:0]       ADDR,
    input  logic [15:0]      DATA,
    input  logic             WREN,
    output logic [15:0]      Q,
    output logic             IRQ
);

    logic [NKEYS-1:0] st;
    logic [NKEYS-1:0] rise;
    logic [NKEYS-1:0] fall;
    logic [NKEYS-1:0] press;
    logic [NKEYS-1:0] rel;
    logic [7:0]       pcount;
    logic [7:0]       n_press;
    logic             wr_press;
    logic             wr_rel;
    logic             wr_pcount;
    logic             unused_data;

    for (genvar i = 0; i < NKEYS; i++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk (CLK),
            .rst (RST),
            .key (KEY[i]),
            .st  (st[i]),
            .rise(rise[i]),
            .fall(fall[i])
        );
    end

    always_comb begin
        n_press = 8'd0;
        for (int i = 0; i < NKEYS; i++) begin
            n_press = n_press + 8'(rise[i]);
        end
    end

    assign wr_press  = WREN && (ADDR == KP_PRESS);
    assign wr_rel    = WREN && (ADDR == KP_RELEASE);
    assign wr_pcount = WREN && (ADDR == KP_PCOUNT);
    assign unused_data = ^DATA[15:NKEYS];

    // Event sets are OR-ed in after the clear, so a set always wins.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            press  <= '0;
            rel    <= '0;
            pcount <= 8'd0;
        end else begin
            press  <= (press & ~({NKEYS{wr_press}} & DATA[NKEYS-1:0])) | rise;
            rel    <= (rel & ~({NKEYS{wr_rel}} & DATA[NKEYS-1:0])) | fall;
            pcount <= kp_sat_add(wr_pcount ? 8'd0 : pcount, n_press);
        end
    end

    always_comb begin
        Q = 16'd0;
        unique case (ADDR)
            KP_STATE:   Q = 16'(st);
            KP_PRESS:   Q = 16'(press);
            KP_RELEASE: Q = 16'(rel);
            KP_PCOUNT:  Q = {8'd0, pcount};
        endcase
    end

    assign IRQ = |press;

endmodule

// File: tb/tb_key_port.sv
// Directed self-checking bench for key_port with DEBOUNCE_CYCLES=4.
// Expected register values are queued, then drained against Q/IRQ.
`timescale 1ns/1ns
module tb_key_port;

    localparam int DB = 4;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [3:0]  KEY = 4'hF;
    logic [1:0]  ADDR = 2'd0;
    logic [15:0] DATA = 16'd0;
    logic        WREN = 1'b0;
    logic [15:0] Q;
    logic        IRQ;

    int checks = 0;
    int errors = 0;
    int pc_model;

    typedef struct {
        string       tag;
        logic        is_irq;
        logic [1:0]  addr;
        logic [15:0] val;
    } exp_t;

    exp_t sb[$];

    key_port #(
        .DEBOUNCE_CYCLES(DB),
        .NKEYS(4)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .KEY (KEY),
        .ADDR(ADDR),
        .DATA(DATA),
        .WREN(WREN),
        .Q   (Q),
        .IRQ (IRQ)
    );

    always #10 CLK = ~CLK;

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        ADDR = a;
        DATA = d;
        WREN = 1'b1;
        step(1);
        WREN = 1'b0;
        DATA = 16'd0;
    endtask

    task automatic exp_reg(input string tag, input logic [1:0] a,
                           input logic [15:0] v);
        exp_t e;
        e.tag = tag;
        e.is_irq = 1'b0;
        e.addr = a;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic exp_irq(input string tag, input logic v);
        exp_t e;
        e.tag = tag;
        e.is_irq = 1'b1;
        e.addr = 2'd0;
        e.val = {15'd0, v};
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        logic [15:0] obs;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (!e.is_irq) ADDR = e.addr;
            #1;
            obs = e.is_irq ? {15'd0, IRQ} : Q;
            checks++;
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s: got %h expected %h", e.tag, obs, e.val);
            end
        end
    endtask

    initial begin
        // reset state
        #3;
        exp_reg("rst_state", 2'd0, 16'h0);
        exp_reg("rst_press", 2'd1, 16'h0);
        exp_reg("rst_rel", 2'd2, 16'h0);
        exp_reg("rst_pcount", 2'd3, 16'h0);
        exp_irq("rst_irq", 1'b0);
        drain();
        step(2);
        RST = 1'b0;
        step(3);

        // clean press on key 0
        KEY = 4'b1110;
        step(DB + 1);
        exp_reg("clean_early_state", 2'd0, 16'h0);
        exp_reg("clean_early_press", 2'd1, 16'h0);
        exp_irq("clean_early_irq", 1'b0);
        drain();
        step(1);
        exp_reg("clean_state", 2'd0, 16'h1);
        exp_reg("clean_press", 2'd1, 16'h1);
        exp_reg("clean_pcount", 2'd3, 16'h1);
        exp_irq("clean_irq", 1'b1);
        drain();

        // release, then clear everything
        KEY = 4'hF;
        step(DB + 2);
        exp_reg("rel_state", 2'd0, 16'h0);
        exp_reg("rel_release", 2'd2, 16'h1);
        drain();
        wr(2'd1, 16'hF);
        wr(2'd2, 16'hF);
        wr(2'd3, 16'h0);
        exp_reg("clr_press", 2'd1, 16'h0);
        exp_reg("clr_rel", 2'd2, 16'h0);
        exp_reg("clr_pcount", 2'd3, 16'h0);
        drain();

        // bounce: low 3, high 1, then low steady
        KEY = 4'b1110;
        step(3);
        KEY = 4'b1111;
        step(1);
        KEY = 4'b1110;
        step(DB + 1);
        exp_reg("bounce_early_state", 2'd0, 16'h0);
        exp_reg("bounce_early_press", 2'd1, 16'h0);
        drain();
        step(1);
        exp_reg("bounce_state", 2'd0, 16'h1);
        exp_reg("bounce_press", 2'd1, 16'h1);
        exp_reg("bounce_pcount", 2'd3, 16'h1);
        drain();

        // W1C on PRESS
        KEY = 4'b1100;
        step(DB + 2);
        exp_reg("w1c_press3", 2'd1, 16'h3);
        exp_reg("w1c_pcount", 2'd3, 16'h2);
        drain();
        wr(2'd1, 16'h1);
        exp_reg("w1c_press2", 2'd1, 16'h2);
        exp_irq("w1c_irq1", 1'b1);
        drain();
        wr(2'd1, 16'h2);
        exp_reg("w1c_press0", 2'd1, 16'h0);
        exp_irq("w1c_irq0", 1'b0);
        drain();

        // set wins over clear in the same edge
        KEY = 4'b1000;
        step(DB + 1);
        wr(2'd1, 16'h4);
        exp_reg("setwin_press", 2'd1, 16'h4);
        exp_reg("setwin_pcount", 2'd3, 16'h3);
        drain();

        // saturation over 260 press/release cycles on key 3
        wr(2'd3, 16'h0);
        wr(2'd2, 16'hF);
        pc_model = 0;
        for (int i = 0; i < 260; i++) begin
            KEY[3] = 1'b0;
            step(DB + 2);
            KEY[3] = 1'b1;
            step(DB + 2);
            if (pc_model < 255) pc_model++;
        end
        exp_reg("sat_pcount", 2'd3, 16'(pc_model));
        exp_reg("sat_release", 2'd2, 16'h8);
        exp_reg("sat_state", 2'd0, 16'h7);
        drain();
        wr(2'd3, 16'h1234);
        exp_reg("sat_clear", 2'd3, 16'h0);
        drain();

        // reset during the debounce of key 1
        KEY = 4'hF;
        step(DB + 2);
        wr(2'd1, 16'hF);
        wr(2'd2, 16'hF);
        wr(2'd3, 16'h0);
        KEY = 4'b1110;
        step(DB + 2);
        exp_reg("pre_rst_press", 2'd1, 16'h1);
        drain();
        KEY = 4'b1100;
        step(3);
        RST = 1'b1;
        #1;
        exp_reg("mid_rst_state", 2'd0, 16'h0);
        exp_reg("mid_rst_press", 2'd1, 16'h0);
        exp_reg("mid_rst_rel", 2'd2, 16'h0);
        exp_reg("mid_rst_pcount", 2'd3, 16'h0);
        exp_irq("mid_rst_irq", 1'b0);
        drain();
        KEY = 4'b1101;
        step(1);
        RST = 1'b0;
        step(DB + 1);
        exp_reg("post_rst_early", 2'd1, 16'h0);
        drain();
        step(1);
        exp_reg("post_rst_press", 2'd1, 16'h2);
        exp_reg("post_rst_state", 2'd0, 16'h2);
        exp_reg("post_rst_pcount", 2'd3, 16'h1);
        drain();

        // two simultaneous presses meeting a PCOUNT write
        KEY = 4'b0001;
        step(DB + 1);
        wr(2'd3, 16'h0);
        exp_reg("multi_pcount", 2'd3, 16'h2);
        exp_reg("multi_press", 2'd1, 16'hE);
        exp_irq("multi_irq", 1'b1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_port.md
# key_port

Memory-mapped push-button input controller for the CPU core. It synchronises and debounces the four active-low board keys, then records press and release events in sticky registers. The core reads and clears these registers over the same ADDR/DATA/WREN/Q bus style the core uses for RAM and the GPU. The segment LED driver is the core's output path to the user; this block is the matching input path from the user.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles needed to accept a level change (10 ms at 50 MHz); minimum 2.
- NKEYS, 4: number of keys.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- RST  in  1  reset; asynchronous, active-high.
- KEY  in  NKEYS  raw key pins, active-low (0 = pressed); bit i is key i in every register.
- ADDR  in  2  register select.
- DATA  in  16  write data.
- WREN  in  1  write strobe, sampled at the rising CLK edge.
- Q  out  16  read data, combinational from ADDR and register state.
- IRQ  out  1  high while any PRESS bit is set.

## Operation
- Each key passes through a 2-flop synchroniser, then is inverted so that 1 = pressed (key_s).
- Per key:
  - Keep a stable level `st` and a debounce counter `cnt` of width $clog2(DEBOUNCE_CYCLES).
  - If key_s == st, set cnt to 0.
  - Otherwise, increment cnt. When key_s != st and cnt == DEBOUNCE_CYCLES-1, set st <= key_s and cnt <= 0.
  - Any bounce back to st before that point restarts the count from 0.
- Events:
  - st rising 0->1 sets PRESS[i].
  - st falling 1->0 sets RELEASE[i].
  - Each press also increments PCOUNT, an 8-bit counter that saturates at 255.
  - Simultaneous presses on several keys in the same cycle add the number of keys pressed, still saturating at 255.
- Registers (read value on Q; upper bits read as 0):
  - ADDR 0, STATE: {12'b0, st[3:0]}. Writes are ignored.
  - ADDR 1, PRESS: {12'b0, PRESS}. Write-1-to-clear using DATA[3:0].
  - ADDR 2, RELEASE: {12'b0, RELEASE}. Write-1-to-clear using DATA[3:0].
  - ADDR 3, PCOUNT: {8'b0, PCOUNT}. Any write clears it to 0.
- Conflicts: if an event sets a bit in the same cycle a write clears it, the set wins. If a press arrives in the same cycle as a PCOUNT write, PCOUNT becomes the number of keys pressed that cycle.
- IRQ = |PRESS, combinational from the register.

## Timing
- Reset values:
  - Synchroniser flops: 1 (released level).
  - st, cnt, PRESS, RELEASE, PCOUNT: 0.
  - IRQ: 0.
  - Q: reflects these values for the current ADDR.
- Latency: a raw KEY change held steady before edge 0 becomes visible in STATE, PRESS/RELEASE and IRQ after edge DEBOUNCE_CYCLES+1, i.e. 2 synchroniser edges plus DEBOUNCE_CYCLES counting edges, minus overlap.
- Reads have zero latency: Q follows ADDR combinationally within the same cycle, so the core can sample it the way it samples RAM_Q.
- Writes take effect at the rising edge where WREN=1. A read in the next cycle shows the cleared value.
- Reset asserted mid-debounce immediately clears cnt and st. After release, a key still held down is treated as a new press after the full latency.
- Pulses shorter than DEBOUNCE_CYCLES cycles produce no event.

## Structure
- Package key_port_pkg holds:
  - Address constants: KP_STATE=0, KP_PRESS=1, KP_RELEASE=2, KP_PCOUNT=3.
  - KP_KEY_IDLE=1'b1 (raw released level).
  - KP_PCOUNT_MAX=8'd255.
- Sub-module key_debounce: one key's synchroniser, counter and stable level. It outputs st plus single-cycle rise and fall strobes and is instantiated NKEYS times in a generate loop.
- The top level holds the sticky registers, PCOUNT, the write decode and the Q mux.
- Integration in top: give key_port its own mem_selector leg. The core's IN port no longer needs the raw keys.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.
- Clean press: KEY=4'b1110 held from edge 0 -> at edge 5, STATE=0x0001, PRESS=0x0001, PCOUNT=1, IRQ=1. Nothing changes before edge 5.
- Bounce: KEY[0] pulses low for 3 cycles, high for 1, then low steady -> a single PRESS, with STATE set 5 edges after the last transition. PCOUNT=1.
- W1C: PRESS=0x0003; write ADDR=1, DATA=0x0001 -> PRESS=0x0002, IRQ=1. Then write DATA=0x0002 -> PRESS=0, IRQ=0.
- Set-wins: a debounced press on key 2 lands in the same edge as a write ADDR=1, DATA=0x0004 -> PRESS[2]=1 afterwards.
- Saturation and release: 260 press/release cycles on key 3 -> PCOUNT=255 and RELEASE=0x0008. A write to ADDR=3 -> PCOUNT=0.
- Reset mid-operation: assert RST 2 cycles into the debounce of key 1 with PRESS=0x0001 -> all registers read 0 and IRQ=0 immediately. After release with key 1 still held, PRESS=0x0002 5 edges later.
